// File: rtl/cpu_package.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding and the instruction-memory geometry.
package cpu_package;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        LOAD   = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one combinational read port.
// Contents are never cleared, so words survive reset and reload.
module imem_ram
    import cpu_package::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [IMEM_ADDR_W-1:0] wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [IMEM_ADDR_W-1:0] rd_addr,
    output logic [31:0]            rd_data
);

    logic [31:0] r_mem [DEPTH];

    // Write port; a same-address read in the write cycle still sees the old word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream (count header followed by little-endian words) into
// instruction memory and releases the core reset once the image is complete.
module imem_loader
    import cpu_package::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    input  logic                   reload,
    input  logic [IMEM_ADDR_W-1:0] imem_reg,
    output logic [31:0]            imem_data,
    output logic                   core_reset_n,
    output logic [6:0]             word_count,
    output logic                   error
);

    localparam logic [7:0] MAX_WORDS = 8'(DEPTH);

    loader_state_t r_state;
    loader_state_t w_next_state;
    logic [6:0]    r_word_count;
    logic [6:0]    r_hdr_n;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_low;
    logic          r_core_reset_n;
    logic          r_error;

    logic          w_rx_ready;
    logic          w_accept;
    logic          w_wr_en;
    logic          w_last_word;
    logic          w_reload_hit;

    assign w_rx_ready   = (r_state == HEADER) || (r_state == LOAD);
    assign w_accept     = rx_valid && w_rx_ready;
    assign w_wr_en      = w_accept && (r_state == LOAD) && (r_byte_idx == 2'd3);
    assign w_last_word  = w_wr_en && (r_word_count == (r_hdr_n - 7'd1));
    assign w_reload_hit = reload && ((r_state == DONE) || (r_state == ERROR));

    // Next-state decode; reload only has an effect once loading has finished
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HEADER: begin
                if (w_accept) begin
                    if (rx_data == 8'd0) begin
                        w_next_state = DONE;
                    end else if (rx_data > MAX_WORDS) begin
                        w_next_state = ERROR;
                    end else begin
                        w_next_state = LOAD;
                    end
                end else begin
                    w_next_state = HEADER;
                end
            end
            LOAD: begin
                if (w_last_word) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = LOAD;
                end
            end
            DONE, ERROR: begin
                if (reload) begin
                    w_next_state = HEADER;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = HEADER;
        endcase
    end

    // State, flags and core reset; core_reset_n rises one cycle after DONE entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= HEADER;
            r_error        <= 1'b0;
            r_core_reset_n <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_error        <= (w_next_state == ERROR);
            r_core_reset_n <= (r_state == DONE) && (w_next_state == DONE);
        end
    end

    // Header latch, byte assembler and word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr_n      <= 7'd0;
            r_byte_idx   <= 2'd0;
            r_low        <= 24'd0;
            r_word_count <= 7'd0;
        end else begin
            if (w_accept && (r_state == HEADER)) begin
                r_hdr_n <= rx_data[6:0];
            end
            if (w_accept && (r_state == LOAD)) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_low[7:0]   <= rx_data;
                    2'd1:    r_low[15:8]  <= rx_data;
                    2'd2:    r_low[23:16] <= rx_data;
                    default: r_low        <= r_low;
                endcase
            end else if (w_reload_hit) begin
                r_byte_idx <= 2'd0;
            end
            if (w_wr_en) begin
                r_word_count <= r_word_count + 7'd1;
            end else if (w_reload_hit) begin
                r_word_count <= 7'd0;
            end
        end
    end

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_word_count[IMEM_ADDR_W-1:0]),
        .wr_data ({rx_data, r_low}),
        .rd_addr (imem_reg),
        .rd_data (imem_data)
    );

    assign rx_ready     = w_rx_ready;
    assign core_reset_n = r_core_reset_n;
    assign word_count   = r_word_count;
    assign error        = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: images are generated as word lists and the
// expected memory is the list itself; bytes are fed with random gaps and reloads.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic [5:0]  imem_reg;
    logic [31:0] imem_data;
    logic        core_reset_n;
    logic [6:0]  word_count;
    logic        error;

    int errs   = 0;
    int checks = 0;

    logic [31:0] w_buf   [64];
    logic [31:0] m_mem   [64];
    bit          m_valid [64];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .imem_reg     (imem_reg),
        .imem_data    (imem_data),
        .core_reset_n (core_reset_n),
        .word_count   (word_count),
        .error        (error)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input int wc, input bit rdy, input bit crn, input bit err);
        check_eq({tag, "_word_count"}, {25'd0, word_count}, 32'(wc));
        check_eq({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, rdy});
        check_eq({tag, "_core_reset_n"}, {31'd0, core_reset_n}, {31'd0, crn});
        check_eq({tag, "_error"}, {31'd0, error}, {31'd0, err});
    endtask

    // One byte, preceded by 0-2 idle cycles with junk data; optional ignored reload
    task automatic send_byte(input logic [7:0] b, input bit rl_ok, input bit chk_old, input logic [31:0] old_w);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            reload   = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        reload   = rl_ok && ($urandom_range(0, 3) == 0);
        check_eq("rx_ready_load", {31'd0, rx_ready}, 32'd1);
        if (chk_old) check_eq("same_cycle_old_word", imem_data, old_w);
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    // Header n followed by words w_buf[0..n-1]; checks DONE entry and core release
    task automatic do_load(input int n);
        send_byte(8'(n), 1'b1, 1'b0, 32'd0);
        for (int w = 0; w < n; w++) begin
            imem_reg = 6'(w);
            for (int b = 0; b < 4; b++) begin
                send_byte(w_buf[w][8*b +: 8], 1'b1, (b == 3) && m_valid[w], m_mem[w]);
            end
            #1;
            check_eq("write_visible", imem_data, w_buf[w]);
            m_mem[w]   = w_buf[w];
            m_valid[w] = 1'b1;
        end
        go_idle();
        check_status("done_entry", n, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_status("done_release", n, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_status("after_reload", 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 64; i++) begin
            if (m_valid[i]) begin
                @(negedge clk);
                imem_reg = 6'(i);
                #1;
                check_eq($sformatf("mem[%0d]", i), imem_data, m_mem[i]);
            end
        end
    endtask

    task automatic bad_header(input logic [7:0] h);
        send_byte(h, 1'b1, 1'b0, 32'd0);
        go_idle();
        check_status("err_entry", 0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_status("err_hold", 0, 1'b0, 1'b0, 1'b1);
        do_reload();
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        reload   = 1'b0;
        imem_reg = 6'd0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_status("reset", 0, 1'b1, 1'b0, 1'b0);

        // Normal two-word image
        w_buf[0] = 32'h0000_0013;
        w_buf[1] = 32'h0010_0093;
        do_load(2);
        imem_reg = 6'd0; #1;
        check_eq("addr0", imem_data, 32'h0000_0013);
        imem_reg = 6'd1; #1;
        check_eq("addr1", imem_data, 32'h0010_0093);

        // Reload in DONE keeps the old image readable
        do_reload();
        check_mem();

        // Zero header: straight to DONE, nothing written
        do_load(0);
        check_mem();
        do_reload();

        // Out-of-range headers
        bad_header(8'd65);
        bad_header(8'($urandom_range(65, 255)));

        // Stall then reset mid-word, then a clean one-word image
        send_byte(8'd1, 1'b0, 1'b0, 32'd0);
        send_byte(8'hAA, 1'b0, 1'b0, 32'd0);
        send_byte(8'hBB, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_status("mid_load_reset", 0, 1'b1, 1'b0, 1'b0);
        check_mem();
        w_buf[0] = 32'h0403_0201;
        do_load(1);
        imem_reg = 6'd0; #1;
        check_eq("addr0_after_reset", imem_data, 32'h0403_0201);
        do_reload();

        // Full 64-word image
        for (int i = 0; i < 64; i++) w_buf[i] = $urandom;
        do_load(64);
        check_mem();
        imem_reg = 6'd63; #1;
        check_eq("addr63", imem_data, w_buf[63]);
        do_reload();

        // Random partial images over stale contents
        for (int t = 0; t < 3; t++) begin
            int n;
            n = $urandom_range(1, 64);
            for (int i = 0; i < 64; i++) w_buf[i] = $urandom;
            do_load(n);
            check_mem();
            do_reload();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning instruction words held (address width 6).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port rx_valid  input  1  byte-stream valid.
REQ-005 The block SHALL have port rx_data  input  8  byte-stream data.
REQ-006 The block SHALL have port rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high.
REQ-007 The block SHALL have port reload  input  1  single-cycle request to restart loading.
REQ-008 The block SHALL have port imem_reg  input  6  core instruction word address.
REQ-009 The block SHALL have port imem_data  output  32  instruction word at imem_reg.
REQ-010 The block SHALL have port core_reset_n  output  1  registered active-low reset for cpu_core.
REQ-011 The block SHALL have port word_count  output  7  words written in the current load.
REQ-012 The block SHALL have port error  output  1  header-out-of-range flag.

Function
REQ-013 The block SHALL implement states HEADER, LOAD, DONE and ERROR.
REQ-014 rx_ready SHALL be high in HEADER and LOAD, and low in DONE and ERROR.
REQ-015 HEADER: the accepted byte SHALL be N, the word count.
- N=0: go to DONE, no writes.
- 1..64: latch N, go to LOAD.
- N>64: go to ERROR.
REQ-016 LOAD SHALL assemble words little-endian: first byte is bits 7:0, fourth byte is bits 31:24.
REQ-017 The word SHALL be written to address word_count in the cycle its 4th byte is accepted, and SHALL be readable on imem_data the following cycle.
REQ-018 word_count SHALL increment with each word write.
REQ-019 When the write of word N-1 occurs, the block SHALL move to DONE in the same edge.
REQ-020 rx_valid low SHALL stall assembly with no state change.
REQ-021 The byte index SHALL be 2 bits and SHALL wrap 3->0 on each word write.
REQ-022 core_reset_n SHALL be registered: 1 one cycle after DONE is entered, 0 in every other state.
REQ-023 imem_data SHALL be a combinational read of the array at imem_reg in all states.
REQ-024 Read and write of the same address in the same cycle SHALL return the old word.
REQ-025 reload in DONE or ERROR SHALL go to HEADER and clear word_count, error and the byte index.
- core_reset_n SHALL fall on the next edge.
REQ-026 reload in HEADER or LOAD SHALL be ignored, including a reload coinciding with the final word write, which still enters DONE.
REQ-027 error SHALL be 1 exactly while in ERROR.
REQ-028 Unwritten or stale array words SHALL retain their prior contents; there is no clear.

Reset
REQ-029 When reset is sampled high, the block SHALL set state=HEADER, word_count=0, byte index=0, error=0, core_reset_n=0.
REQ-030 rx_ready SHALL read 1 in the first cycle after reset.
REQ-031 Reset mid-LOAD SHALL discard the partial word; words already written SHALL stay in the array.
REQ-032 The array SHALL not be reset.

Structure
REQ-033 cpu_package SHALL hold loader_state_t (HEADER, LOAD, DONE, ERROR) and constants IMEM_DEPTH=64 and IMEM_ADDR_W=6.
REQ-034 The storage SHALL be a sub-module imem_ram: 64x32, one synchronous write port, one combinational read port.
REQ-035 The FSM, byte assembler and counters SHALL live in imem_loader.

Verification
REQ-036 The bench SHALL cover a normal load.
- Stimulus: header 2, then bytes 13 00 00 00, 93 00 10 00.
- Response: addr0=0x00000013, addr1=0x00100093, word_count=2, core_reset_n=1 one cycle after DONE.
REQ-037 The bench SHALL cover a zero header: header 0 -> DONE next cycle, array unchanged, core_reset_n=1 one cycle later.
REQ-038 The bench SHALL cover an out-of-range header: header 65 -> error=1, rx_ready=0, core_reset_n=0; then reload -> HEADER, error=0.
REQ-039 The bench SHALL cover stall and reset mid-load.
- Stimulus: header 1, bytes AA BB with rx_valid gaps, reset, then header 1 and bytes 01 02 03 04.
- Response: addr0=0x04030201.
REQ-040 The bench SHALL cover a full load: header 64, 256 bytes -> word_count=64, addr63 holds the last word, index wraps with no overrun.
REQ-041 The bench SHALL cover reload in DONE: core_reset_n=0 next edge, word_count=0, and the old contents are readable until overwritten.
